// File: rtl/race_start_scheduler.sv
// Round-robin start-light sequencer: one shared RED/YELLOW/GREEN tower
// serving N_LANES requesters. The winning lane sees a timed
// RED -> YELLOW -> GREEN sequence. A race can be cancelled at any point by abort.
// This is a pure Moore machine: every output comes directly from a flop.
module race_start_scheduler #(
  parameter int N_LANES = 4,
  parameter int RED_CYC = 3,
  parameter int YEL_CYC = 3,
  parameter int GRN_CYC = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_LANES-1:0] req,
  input  logic               abort,
  output logic               red,
  output logic               yellow,
  output logic               green,
  output logic               busy,
  output logic [N_LANES-1:0] grant,
  output logic               done,
  output logic               aborted
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  localparam logic [CNT_W-1:0] RED_LOAD = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] GRN_LOAD = CNT_W'(GRN_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RED,
    S_YELLOW,
    S_GREEN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_LANES-1:0] grant_q, grant_d;
  logic               red_q, red_d;
  logic               yellow_q, yellow_d;
  logic               green_q, green_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;
  int                 scan_int;

  // Round-robin search: first requesting lane strictly after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    scan_int  = 0;
    scan_idx  = '0;
    for (int i = 1; i <= N_LANES; i++) begin
      scan_int = int'(rr_ptr_q) + i;
      if (scan_int >= N_LANES) scan_int = scan_int - N_LANES;
      scan_idx = PTR_W'(scan_int);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state, counter, arbitration and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort is meaningless here; only a request starts a race.
        if (win_found) begin
          state_d  = S_RED;
          cnt_d    = RED_LOAD;
          rr_ptr_d = win_idx;
          grant_d  = N_LANES'(1) << win_idx;
        end
      end
      S_RED, S_YELLOW, S_GREEN: begin
        if (abort) begin
          // Abort beats the normal phase step, even on the last GREEN cycle.
          // rr_ptr keeps the aborted lane so its turn counts as used.
          state_d   = S_IDLE;
          cnt_d     = '0;
          grant_d   = '0;
          aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            S_RED: begin
              state_d = S_YELLOW;
              cnt_d   = YEL_LOAD;
            end
            S_YELLOW: begin
              state_d = S_GREEN;
              cnt_d   = GRN_LOAD;
            end
            default: begin
              state_d = S_IDLE;
              grant_d = '0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase

    // Lamps and busy come from the next state, so they line up with it in the same cycle.
    red_d    = (state_d == S_IDLE) || (state_d == S_RED);
    yellow_d = (state_d == S_YELLOW);
    green_d  = (state_d == S_GREEN);
    busy_d   = (state_d != S_IDLE);
  end

  // All state and outputs are registered here; async reset puts the lamp on red.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= PTR_RST;
      grant_q   <= '0;
      red_q     <= 1'b1;
      yellow_q  <= 1'b0;
      green_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      red_q     <= red_d;
      yellow_q  <= yellow_d;
      green_q   <= green_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign red     = red_q;
  assign yellow  = yellow_q;
  assign green   = green_q;
  assign busy    = busy_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
